// File: rtl/buzzer_tone_gen.sv
// Square-wave tone generator: half-period = CLK_HZ/(2*freq) from a sequential restoring divider.
// Tone changes are applied only at a toggle, so the output never emits a runt pulse.
module buzzer_tone_gen #(
  parameter int CLK_HZ   = 100_000_000,
  parameter int FREQ_W   = 16,
  parameter int CNT_W    = 32,
  parameter int MIN_FREQ = 20,
  parameter int MAX_FREQ = 20000
) (
  input  logic              i_clk,
  input  logic              i_reset_n,
  input  logic              i_en,
  input  logic [FREQ_W-1:0] i_freq,
  output logic              o_buzzer,
  output logic              o_active,
  output logic              o_busy
);

  localparam int BW = $clog2(CNT_W);
  localparam int RW = FREQ_W + 1;
  localparam logic [CNT_W-1:0] DIVIDEND = CNT_W'(CLK_HZ);

  typedef enum logic [1:0] {IDLE, DIVIDE, RUN} state_t;
  state_t state, state_nxt;

  logic              en_q;
  logic [FREQ_W-1:0] freq_q, cur_freq;
  logic [RW-1:0]     rem;
  logic [CNT_W-1:0]  quo, half, half_pend, cnt;
  logic [BW-1:0]     bit_cnt;
  logic              from_run, pend, buzz;

  logic              legal, freq_chg, last, ge;
  logic              start, restart, step, done, tone_on;
  logic [RW-1:0]     dsor, rem_n;
  logic [RW:0]       shifted;
  logic [CNT_W-1:0]  quo_n;

  assign legal    = en_q && (freq_q >= FREQ_W'(MIN_FREQ)) && (freq_q <= FREQ_W'(MAX_FREQ));
  assign freq_chg = (freq_q != cur_freq);
  assign last     = (bit_cnt == BW'(CNT_W - 1));

  // Dividend bits stream out of the top of quo while quotient bits shift in at the bottom.
  assign dsor    = {cur_freq, 1'b0};
  assign shifted = {rem, quo[CNT_W-1]};
  assign ge      = (shifted >= {1'b0, dsor});
  assign rem_n   = ge ? (shifted[RW-1:0] - dsor) : shifted[RW-1:0];
  assign quo_n   = {quo[CNT_W-2:0], ge};

  always_comb begin
    state_nxt = state;
    o_busy    = 1'b0;
    tone_on   = 1'b0;
    start     = 1'b0;
    restart   = 1'b0;
    step      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        if (legal) begin
          start     = 1'b1;
          state_nxt = DIVIDE;
        end
      end
      DIVIDE: begin
        o_busy  = 1'b1;
        tone_on = from_run;
        if (!legal)        state_nxt = IDLE;
        else if (freq_chg) restart = 1'b1;
        else begin
          step = 1'b1;
          if (last) begin
            done      = 1'b1;
            state_nxt = RUN;
          end
        end
      end
      RUN: begin
        tone_on = 1'b1;
        if (!legal) state_nxt = IDLE;
        else if (freq_chg) begin
          start     = 1'b1;
          state_nxt = DIVIDE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign o_active = tone_on;
  assign o_buzzer = buzz;

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) state <= IDLE;
    else            state <= state_nxt;
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      en_q      <= 1'b0;
      freq_q    <= '0;
      cur_freq  <= '0;
      rem       <= '0;
      quo       <= '0;
      bit_cnt   <= '0;
      from_run  <= 1'b0;
      half      <= '0;
      half_pend <= '0;
      pend      <= 1'b0;
      cnt       <= '0;
      buzz      <= 1'b0;
    end else begin
      en_q   <= i_en;
      freq_q <= i_freq;
      if (!legal) begin
        // cur_freq cleared so re-enabling the same tone divides again
        buzz     <= 1'b0;
        cnt      <= '0;
        pend     <= 1'b0;
        cur_freq <= '0;
        bit_cnt  <= '0;
        from_run <= 1'b0;
        rem      <= '0;
        quo      <= '0;
      end else begin
        if (start || restart) begin
          cur_freq <= freq_q;
          bit_cnt  <= '0;
          rem      <= '0;
          quo      <= DIVIDEND;
        end
        if (start) from_run <= (state == RUN);
        if (step) begin
          rem     <= rem_n;
          quo     <= quo_n;
          bit_cnt <= bit_cnt + 1'b1;
        end
        if (done && !from_run) begin
          half <= quo_n;
          cnt  <= '0;
          buzz <= 1'b1;
        end
        // New half-periods only take effect at a toggle, so the current one always completes.
        if (tone_on) begin
          if (cnt == half - 1'b1) begin
            cnt  <= '0;
            buzz <= ~buzz;
            if (done) begin
              half <= quo_n;
              pend <= 1'b0;
            end else if (pend) begin
              half <= half_pend;
              pend <= 1'b0;
            end
          end else begin
            cnt <= cnt + 1'b1;
            if (done) begin
              half_pend <= quo_n;
              pend      <= 1'b1;
            end
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_buzzer_tone_gen.sv
// Directed bench for buzzer_tone_gen at CLK_HZ=1 MHz so every phase stays short.
// Halves: 1046->478, 1318->379, 1569->318, 20->25000.
module tb_buzzer_tone_gen;

  logic        clk, reset_n, en;
  logic [15:0] freq;
  logic        buzzer, active, busy;
  int          checks = 0;
  int          errors = 0;
  int          n;
  logic        acc;

  buzzer_tone_gen #(
    .CLK_HZ(1_000_000), .FREQ_W(16), .CNT_W(32), .MIN_FREQ(20), .MAX_FREQ(20000)
  ) dut (
    .i_clk(clk), .i_reset_n(reset_n), .i_en(en), .i_freq(freq),
    .o_buzzer(buzzer), .o_active(active), .o_busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic nwait(input int k);
    repeat (k) @(negedge clk);
  endtask

  // Length in clocks of the current buzzer phase; called on the phase's first negedge
  // (or later, with start = negedges of the phase already seen). Bounded.
  task automatic phase(input int start, output int len);
    logic p;
    p   = buzzer;
    len = start;
    while (len < 60000) begin
      @(negedge clk);
      if (buzzer !== p) break;
      len++;
    end
  endtask

  // Inputs were just driven on a negedge: busy from the 2nd negedge, first rise on the 34th.
  task automatic rise_seq(input string tag);
    nwait(1);  check({tag, "_busy1"}, busy, 1'b0);
    nwait(1);  check({tag, "_busy2"}, busy, 1'b1);
    nwait(31); check({tag, "_buz33"}, buzzer, 1'b0);
               check({tag, "_busy33"}, busy, 1'b1);
    nwait(1);  check({tag, "_buz34"}, buzzer, 1'b1);
               check({tag, "_busy34"}, busy, 1'b0);
               check({tag, "_act34"}, active, 1'b1);
  endtask

  task automatic quiet(input string tag);
    acc = 1'b0;
    repeat (40) begin
      @(negedge clk);
      acc = acc | busy | buzzer | active;
    end
    check(tag, acc, 1'b0);
  endtask

  initial begin
    reset_n = 1'b1; en = 1'b0; freq = '0;
    #2 reset_n = 1'b0;
    nwait(2);
    check("rst_buz", buzzer, 1'b0);
    check("rst_act", active, 1'b0);
    check("rst_busy", busy, 1'b0);
    reset_n = 1'b1;
    nwait(2);

    // 1: basic tone at 1046 Hz
    en = 1'b1; freq = 16'd1046;
    rise_seq("t1");
    phase(1, n); check("t1_high", n, 478);
    phase(1, n); check("t1_low", n, 478);

    // 2: switch to 1318 at the start of a high phase; old half finishes first
    freq = 16'd1318;
    nwait(2);
    check("t2_busy", busy, 1'b1);
    check("t2_act", active, 1'b1);
    check("t2_buz", buzzer, 1'b1);
    phase(3, n); check("t2_old_high", n, 478);
    phase(1, n); check("t2_low", n, 379);
    phase(1, n); check("t2_high", n, 379);

    // 3: 1569 then disable mid-tone, then re-enable
    freq = 16'd1569;
    nwait(50);
    en = 1'b0;
    nwait(1); check("t3_act_1clk", active, 1'b1);
    nwait(1); check("t3_buz_off", buzzer, 1'b0);
              check("t3_act_off", active, 1'b0);
              check("t3_busy_off", busy, 1'b0);
    nwait(5);
    en = 1'b1;
    rise_seq("t3");
    phase(1, n); check("t3_high", n, 318);
    phase(1, n); check("t3_low", n, 318);

    // 4: out-of-range tones are mute; 20 Hz is the lowest legal tone
    freq = 16'd0;
    nwait(3);
    quiet("t4_f0");
    freq = 16'd19;    quiet("t4_f19");
    freq = 16'd20001; quiet("t4_f20001");
    freq = 16'd20;
    rise_seq("t4");
    phase(1, n); check("t4_high20", n, 25000);

    // 5: change mid-divide restarts it; then async reset mid-run
    en = 1'b0;
    nwait(3);
    en = 1'b1; freq = 16'd1046;
    nwait(10);
    freq = 16'd1569;
    nwait(33); check("t5_busy43", busy, 1'b1);
               check("t5_buz43", buzzer, 1'b0);
    nwait(1);  check("t5_buz44", buzzer, 1'b1);
    phase(1, n); check("t5_high", n, 318);
    phase(1, n); check("t5_low", n, 318);
    nwait(3);
    #2 reset_n = 1'b0;
    #1;
    check("t5_rst_buz", buzzer, 1'b0);
    check("t5_rst_act", active, 1'b0);
    check("t5_rst_busy", busy, 1'b0);
    nwait(2);
    check("t5_rst_hold", {busy, active, buzzer}, 3'b000);
    en = 1'b0;
    reset_n = 1'b1;
    nwait(3);
    check("t5_post", {busy, active, buzzer}, 3'b000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
